// File: rtl/cpu_pkg.sv
// Shared widths and write-buffer state encoding for the CPU A-register stage.
package cpu_pkg;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_TWO   = 2'd2
  } wbuf_state_e;
endpackage

// File: rtl/cpu_areg_stage_if.sv
// Issue-side and memory-write signals of the A-register stage, bundled as one bus.
interface cpu_areg_stage_if;
  import cpu_pkg::*;

  logic              issue_valid;
  logic [WIDTH-1:0]  a_in;
  logic              load_a;
  logic [WIDTH-1:0]  d_in;
  logic              load_d;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              stall;
  logic [WIDTH-1:0]  a_out;
  logic [WIDTH-1:0]  d_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [WIDTH-1:0]  wr_count;

  modport master (
    output issue_valid, a_in, load_a, d_in, load_d, wr_en, wr_data, mem_wready,
    input  stall, a_out, d_out, mem_addr, mem_wdata, mem_wvalid, wr_count
  );

  modport slave (
    input  issue_valid, a_in, load_a, d_in, load_d, wr_en, wr_data, mem_wready,
    output stall, a_out, d_out, mem_addr, mem_wdata, mem_wvalid, wr_count
  );
endinterface

// File: rtl/cpu_wbuf2.sv
// Two-entry in-order memory write buffer; head entry drives the memory port directly.
// state | meaning: WB_EMPTY no entry | WB_ONE head only | WB_TWO head + tail, full
module cpu_wbuf2
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              mem_wready,
  output logic              full,
  output logic              mem_wvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [WIDTH-1:0]  wr_count
);
  wbuf_state_e       state_q, state_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
  logic [WIDTH-1:0]  head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [WIDTH-1:0]  wr_count_q, wr_count_d;
  logic              drain;

  assign drain = (state_q != WB_EMPTY) & mem_wready;

  always_comb begin
    state_d     = state_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    tail_addr_d = tail_addr_q;
    tail_data_d = tail_data_q;
    wr_count_d  = wr_count_q + {{(WIDTH-1){1'b0}}, drain};
    case (state_q)
      WB_EMPTY: if (push) begin
        head_addr_d = push_addr;
        head_data_d = push_data;
        state_d     = WB_ONE;
      end
      WB_ONE: begin
        if (push && drain) begin
          head_addr_d = push_addr;
          head_data_d = push_data;
        end else if (push) begin
          tail_addr_d = push_addr;
          tail_data_d = push_data;
          state_d     = WB_TWO;
        end else if (drain) begin
          state_d = WB_EMPTY;
        end
      end
      // Push without drain cannot reach here: the stage stalls while full and not ready.
      WB_TWO: if (drain) begin
        head_addr_d = tail_addr_q;
        head_data_d = tail_data_q;
        if (push) begin
          tail_addr_d = push_addr;
          tail_data_d = push_data;
        end else begin
          state_d = WB_ONE;
        end
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_EMPTY;
      head_addr_q <= '0;
      head_data_q <= '0;
      tail_addr_q <= '0;
      tail_data_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      tail_addr_q <= tail_addr_d;
      tail_data_q <= tail_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign full       = (state_q == WB_TWO);
  assign mem_wvalid = (state_q != WB_EMPTY);
  assign mem_addr   = head_addr_q;
  assign mem_wdata  = head_data_q;
  assign wr_count   = wr_count_q;
endmodule

// File: rtl/cpu_areg_stage.sv
// CPU A/D register stage: holds A and D, captures pre-step A as write address,
// and stalls issue when the write buffer is full and memory is not ready.
module cpu_areg_stage
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cpu_areg_stage_if.slave  bus
);
  logic [WIDTH-1:0] a_q, a_d, d_q, d_d;
  logic             full, stall, accept, push;

  assign stall  = full & ~bus.mem_wready;
  assign accept = bus.issue_valid & ~stall;
  assign push   = accept & bus.wr_en;

  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (accept && bus.load_a) a_d = bus.a_in;
    if (accept && bus.load_d) d_d = bus.d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Address comes from A as it stood before this step's load_a takes effect.
  cpu_wbuf2 u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (a_q[ADDR_W-1:0]),
    .push_data  (bus.wr_data),
    .mem_wready (bus.mem_wready),
    .full       (full),
    .mem_wvalid (bus.mem_wvalid),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .wr_count   (bus.wr_count)
  );

  assign bus.stall = stall;
  assign bus.a_out = a_q;
  assign bus.d_out = d_q;
endmodule
